// File: rtl/boreal_envelope_bank_if.sv
// Stream bundle for boreal_envelope_bank: sample input side and envelope
// output side, both valid/ready.
//   in_valid/in_ready/in_first/in_x     : channel-interleaved signed samples
//   out_valid/out_ready/out_ch/out_env  : per-channel envelope results
// The block itself uses the slave modport; the sample source / result
// sink uses the master modport.
interface boreal_envelope_bank_if #(
  parameter int W   = 24,
  parameter int CHW = 3
);
  logic                in_valid;
  logic                in_ready;
  logic                in_first;
  logic signed [W-1:0] in_x;
  logic                out_valid;
  logic                out_ready;
  logic [CHW-1:0]      out_ch;
  logic [W-1:0]        out_env;

  modport master (
    output in_valid, in_first, in_x, out_ready,
    input  in_ready, out_valid, out_ch, out_env
  );

  modport slave (
    input  in_valid, in_first, in_x, out_ready,
    output in_ready, out_valid, out_ch, out_env
  );
endinterface

// File: rtl/boreal_envelope_bank.sv
// Multi-channel envelope detector. One squarer and one EMA update unit are
// shared over CH channels whose samples arrive interleaved 0..CH-1. Each
// channel tracks its squared magnitude with a fast attack rate and a slow
// release rate.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   clr       : synchronous clear of envelopes, pipeline and frame_err
//   bus       : slave side of the sample/envelope stream bundle
//   frame_err : sticky, in_first seen while the channel counter was not 0
// Pipeline: S1 holds the saturated square and its channel; S2 is the output
// register, written together with the channel's envelope state.
module boreal_envelope_bank #(
  parameter int W         = 24,
  parameter int CH        = 8,
  parameter int FRAC      = 16,
  parameter int SHIFT_ATT = 3,
  parameter int SHIFT_REL = 6,
  parameter int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  boreal_envelope_bank_if.slave  bus,
  output logic                   frame_err
);

  localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

  // (x*x) >> FRAC, saturated to W bits. The square is formed at 2W bits
  // so that x = -2^(W-1) cannot wrap.
  function automatic logic [W-1:0] sat_square(input logic signed [W-1:0] x);
    logic signed [2*W-1:0] xe;
    logic signed [2*W-1:0] sq;
    logic [2*W-1:0]        sh;
    xe = {{W{x[W-1]}}, x};
    sq = xe * xe;
    sh = $unsigned(sq) >> FRAC;
    if (|sh[2*W-1:W]) begin
      sat_square = '1;
    end else begin
      sat_square = sh[W-1:0];
    end
  endfunction

  logic [CHW-1:0]      ch_cnt_r;
  logic                frame_err_r;
  logic                s1_full_r;
  logic [CHW-1:0]      s1_ch_r;
  logic [W-1:0]        s1_mag_r;
  logic [W-1:0]        env_r [CH];
  logic                out_valid_r;
  logic [CHW-1:0]      out_ch_r;
  logic [W-1:0]        out_env_r;

  logic                flush_s;
  logic                s1_adv_s;
  logic                in_ready_s;
  logic                accept_s;
  logic [CHW-1:0]      in_ch_s;
  logic [CHW-1:0]      ch_next_s;
  logic [W-1:0]        mag_s;
  logic [W-1:0]        env_cur_s;
  logic signed [W:0]   diff_s;
  logic signed [W:0]   step_s;
  logic signed [W:0]   env_sum_s;
  logic [W-1:0]        env_new_s;

  assign flush_s = rst | clr;
  // S1 may move on when the output register is empty or being consumed.
  assign s1_adv_s = s1_full_r & (~out_valid_r | bus.out_ready);
  // Combinational from out_ready so a continuous stream sees no bubble;
  // samples offered during rst/clr are dropped.
  assign in_ready_s = ~flush_s & (~s1_full_r | s1_adv_s);
  assign accept_s   = bus.in_valid & in_ready_s;
  assign mag_s      = sat_square(bus.in_x);

  // Channel of the incoming sample and the counter value after it.
  always_comb begin
    in_ch_s   = '0;
    ch_next_s = '0;
    if (bus.in_first) begin
      in_ch_s = '0;
    end else begin
      in_ch_s = ch_cnt_r;
    end
    if (in_ch_s == LAST_CH) begin
      ch_next_s = '0;
    end else begin
      ch_next_s = in_ch_s + CHW'(1'b1);
    end
  end

  // EMA update. env[] is read here only, in the same cycle it is written,
  // so consecutive samples of one channel always see the previous result.
  always_comb begin
    env_cur_s = env_r[s1_ch_r];
    diff_s    = $signed({1'b0, s1_mag_r}) - $signed({1'b0, env_cur_s});
    step_s    = '0;
    if (!diff_s[W] && (diff_s != '0)) begin
      step_s = diff_s >>> SHIFT_ATT;
    end else begin
      step_s = diff_s >>> SHIFT_REL;
    end
    // Floor shift keeps the sum between env and mag; the top-bit guard is
    // purely defensive and never triggers.
    env_sum_s = $signed({1'b0, env_cur_s}) + step_s;
    if (env_sum_s[W]) begin
      env_new_s = '1;
    end else begin
      env_new_s = env_sum_s[W-1:0];
    end
  end

  // Channel counter and sticky framing error.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      ch_cnt_r    <= '0;
      frame_err_r <= 1'b0;
    end else if (accept_s) begin
      ch_cnt_r <= ch_next_s;
      if (bus.in_first && (ch_cnt_r != '0)) begin
        frame_err_r <= 1'b1;
      end
    end
  end

  // Stage S1: squared magnitude and channel of the accepted sample.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      s1_full_r <= 1'b0;
      s1_ch_r   <= '0;
      s1_mag_r  <= '0;
    end else if (accept_s) begin
      s1_full_r <= 1'b1;
      s1_ch_r   <= in_ch_s;
      s1_mag_r  <= mag_s;
    end else if (s1_adv_s) begin
      s1_full_r <= 1'b0;
    end
  end

  // Output register; holds its contents while stalled.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_env_r   <= '0;
    end else if (s1_adv_s) begin
      out_valid_r <= 1'b1;
      out_ch_r    <= s1_ch_r;
      out_env_r   <= env_new_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Per-channel envelope state, written only when S1 moves to the output.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      for (int i = 0; i < CH; i++) begin
        env_r[i] <= '0;
      end
    end else if (s1_adv_s) begin
      env_r[s1_ch_r] <= env_new_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_env   = out_env_r;
  assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_boreal_envelope_bank.sv
// Bench for boreal_envelope_bank: an 8-channel instance driven from a table
// of hand-computed vectors plus model-backed sequences, and a 1-channel
// instance streamed continuously.
module tb_boreal_envelope_bank;
  localparam int W = 24;

  typedef struct {
    bit first;
    int x;
    int ech;
    int eenv;
  } vec_t;

  logic clk;
  logic rst;
  logic clr;
  logic rst1;
  logic clr1;
  logic frame_err;
  logic frame_err1;

  int   checks;
  int   errors;
  int   q_ch[$];
  int   q_env[$];
  int   q1[$];
  int   env_m[8];
  int   cnt_m;
  bit   fe_m;
  int   last_env[8];
  int   env1;
  vec_t tbl[24];

  boreal_envelope_bank_if #(.W(W), .CHW(3)) b8 ();
  boreal_envelope_bank_if #(.W(W), .CHW(1)) b1 ();

  boreal_envelope_bank #(.W(W), .CH(8), .FRAC(16), .SHIFT_ATT(3), .SHIFT_REL(6)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .bus(b8.slave), .frame_err(frame_err)
  );

  boreal_envelope_bank #(.W(W), .CH(1), .FRAC(16), .SHIFT_ATT(3), .SHIFT_REL(6)) dut1 (
    .clk(clk), .rst(rst1), .clr(clr1), .bus(b1.slave), .frame_err(frame_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int magf(input int x);
    longint sq;
    longint m;
    sq = longint'(x) * longint'(x);
    m  = sq >>> 16;
    if (m > 64'sd16777215) m = 64'sd16777215;
    return int'(m);
  endfunction

  function automatic int ema(input int env, input int mag);
    int d;
    d = mag - env;
    if (d > 0) return env + (d >>> 3);
    return env + (d >>> 6);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  // One clock on the 8-channel instance: score any output transfer, record
  // any input transfer with its expected result, then advance to the next
  // falling edge.
  task automatic tick(input int ech, input int eenv, output bit acc);
    int c;
    int e;
    #1;
    if (b8.out_valid && b8.out_ready) begin
      if (q_ch.size() == 0) begin
        fail("spurious_out");
      end else begin
        c = q_ch.pop_front();
        e = q_env.pop_front();
        chk("out_ch", b8.out_ch, c);
        chk("out_env", b8.out_env, e);
        last_env[c] = int'(b8.out_env);
      end
    end
    acc = b8.in_valid && b8.in_ready;
    if (acc) begin
      q_ch.push_back(ech);
      q_env.push_back(eenv);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic xfer(input int x, input bit first, input int ech, input int eenv, output bit acc);
    b8.in_valid = 1'b1;
    b8.in_first = first;
    b8.in_x     = W'(x);
    tick(ech, eenv, acc);
  endtask

  // Offer one sample for one cycle; expected result from the channel model.
  task automatic mtry(input int x, input bit first, output bit acc);
    int ch;
    int ne;
    ch = first ? 0 : cnt_m;
    ne = ema(env_m[ch], magf(x));
    xfer(x, first, ch, ne, acc);
    if (acc) begin
      if (first && cnt_m != 0) fe_m = 1'b1;
      env_m[ch] = ne;
      cnt_m = (ch == 7) ? 0 : ch + 1;
    end
  endtask

  task automatic send_m(input int x, input bit first);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) mtry(x, first, acc);
    if (!acc) fail("accept_timeout");
  endtask

  // Send with a hand-computed expectation and bring the model in line.
  task automatic send_v(input int x, input bit first, input int ech, input int eenv);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) xfer(x, first, ech, eenv, acc);
    if (!acc) fail("accept_timeout");
    env_m[ech] = eenv;
    cnt_m = (ech == 7) ? 0 : ech + 1;
  endtask

  task automatic drain();
    bit acc;
    b8.in_valid = 1'b0;
    b8.in_first = 1'b0;
    for (int i = 0; i < 30 && q_ch.size() != 0; i++) tick(0, 0, acc);
    chk("drain_empty", q_ch.size(), 0);
    tick(0, 0, acc);
    tick(0, 0, acc);
  endtask

  // One clock on the 1-channel instance with a continuous stream.
  task automatic step1(input int x);
    int e;
    b1.in_x     = W'(x);
    b1.in_first = 1'b0;
    #1;
    chk("ch1_in_ready", b1.in_ready, 1);
    if (b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        fail("ch1_spurious_out");
      end else begin
        e = q1.pop_front();
        chk("ch1_out_env", b1.out_env, e);
        chk("ch1_out_ch", b1.out_ch, 0);
      end
    end
    if (b1.in_valid && b1.in_ready) begin
      env1 = ema(env1, magf(x));
      q1.push_back(env1);
    end
    chk("ch1_latency", q1.size() <= 2, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit          acc;
    int          k;
    logic [23:0] held_env;
    logic [2:0]  held_ch;

    checks = 0;
    errors = 0;
    rst = 1'b1; rst1 = 1'b1; clr = 1'b0; clr1 = 1'b0;
    b8.in_valid = 1'b0; b8.in_first = 1'b0; b8.in_x = '0; b8.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_first = 1'b0; b1.in_x = '0; b1.out_ready = 1'b1;
    cnt_m = 0; fe_m = 1'b0; env1 = 0;
    for (int i = 0; i < 8; i++) begin
      env_m[i] = 0;
      last_env[i] = -1;
    end

    // Two rounds of mag=256 (attack 32, 60), then a mixed third round.
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{1'b0, 4096, i, 32};
      tbl[8 + i] = '{1'b0, 4096, i, 60};
    end
    tbl[16] = '{1'b0, 4096, 0, 84};
    tbl[17] = '{1'b0, 4096, 1, 84};
    tbl[18] = '{1'b0, 4096, 2, 84};
    tbl[19] = '{1'b0, 0, 3, 59};              // 60 + floor(-60/64)
    tbl[20] = '{1'b0, -8388608, 4, 2097204};  // mag saturates to 16777215
    tbl[21] = '{1'b0, -4096, 5, 84};
    tbl[22] = '{1'b0, 100, 6, 59};            // mag 0
    tbl[23] = '{1'b0, 65535, 7, 8244};        // mag 65534

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_out_ch", b8.out_ch, 0);
    chk("rst_out_env", b8.out_env, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    rst1 = 1'b0;
    #1;
    chk("ready_after_rst", b8.in_ready, 1);

    // Table-driven vectors.
    for (int r = 0; r < 24; r++) send_v(tbl[r].x, tbl[r].first, tbl[r].ech, tbl[r].eenv);
    drain();

    // in_first at ch_cnt=5: routed to ch0, counter continues at 1.
    for (int i = 0; i < 5; i++) send_m(4096, 1'b0);
    send_m(4096, 1'b1);
    send_m(4096, 1'b0);
    drain();
    chk("frame_err_set", frame_err, fe_m);
    for (int i = 0; i < 3; i++) tick(0, 0, acc);
    chk("frame_err_sticky", frame_err, 1);

    // clr: sample offered in the clr cycle is dropped.
    clr = 1'b1;
    b8.in_valid = 1'b1;
    b8.in_x = W'(4096);
    #1;
    chk("clr_in_ready", b8.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    b8.in_valid = 1'b0;
    chk("clr_frame_err", frame_err, 0);
    chk("clr_out_valid", b8.out_valid, 0);
    for (int i = 0; i < 8; i++) env_m[i] = 0;
    cnt_m = 0;
    fe_m = 1'b0;

    // Most negative input from a zeroed envelope, then ch1 proves zeroing.
    send_v(-8388608, 1'b0, 0, 2097151);
    send_v(4096, 1'b0, 1, 32);
    drain();
    chk("sat_first_env", last_env[0], 2097151);

    // ch3 attacks with mag=256 for 40 updates, others see 0.
    for (int i = 0; i < 320; i++) send_m((cnt_m == 3) ? 4096 : 0, 1'b0);
    drain();
    chk("attack_converged", last_env[3], 249);
    chk("other_ch_zero", last_env[2], 0);
    for (int i = 0; i < 8; i++) send_m(0, 1'b0);
    drain();
    chk("release_step", last_env[3], 245);
    for (int r = 0; r < 300 && env_m[3] != 0; r++)
      for (int i = 0; i < 8; i++) send_m(0, 1'b0);
    drain();
    chk("release_zero", last_env[3], 0);

    // Output stall with continuous input.
    b8.out_ready = 1'b0;
    k = 0;
    held_env = '0;
    held_ch = '0;
    for (int c = 0; c < 7; c++) begin
      mtry(5000 * (k + 1), 1'b0, acc);
      if (acc) k++;
      if (c == 3) begin
        held_env = b8.out_env;
        held_ch = b8.out_ch;
      end
    end
    chk("stall_in_ready", b8.in_ready, 0);
    chk("stall_out_valid", b8.out_valid, 1);
    chk("stall_hold_env", b8.out_env, held_env);
    chk("stall_hold_ch", b8.out_ch, held_ch);
    chk("stall_accepted", k, 2);
    b8.out_ready = 1'b1;
    for (int j = k; j < 6; j++) send_m(5000 * (j + 1), 1'b0);
    drain();

    // Single-channel continuous stream, then rst mid-stream.
    b1.in_valid = 1'b1;
    for (int c = 0; c < 16; c++)
      step1((c < 6) ? 4096 : (c < 10) ? 0 : (c == 10) ? -8388608 : 2000 * c);
    rst1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    chk("ch1_rst_out_valid", b1.out_valid, 0);
    chk("ch1_rst_out_env", b1.out_env, 0);
    chk("ch1_rst_out_ch", b1.out_ch, 0);
    chk("ch1_rst_frame_err", frame_err1, 0);
    q1.delete();
    env1 = 0;
    for (int c = 0; c < 8; c++) step1(4096 + 1000 * c);
    b1.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step1(0);
    chk("ch1_drain_empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
